// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: width helpers and frame sideband type; ADDER_TREE_ACC_SIGNED_EN selects two's complement arithmetic
package adder_tree_pkg;

`ifdef ADDER_TREE_ACC_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct packed {
        logic valid;
        logic last;
        logic forced;
    } ctrl_t;

    function automatic int tree_st(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int o_data_w(input int w, input int n);
        return w + $clog2(n);
    endfunction

    function automatic int acc_w(input int w, input int n, input int a);
        return o_data_w(w, n) + $clog2(a) + ((a > 1 && (a & (a - 1)) == 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered pairwise-add level of the reduction tree
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int IN_N = 2,
    parameter int IN_W = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  ctrl_t                        ctrl,
    input  logic [0:IN_N-1][IN_W-1:0]    data,
    output ctrl_t                        sum_ctrl,
    output logic [0:IN_N/2-1][IN_W:0]    sum
);

    // sideband travels with the data; only its valid bit matters after reset
    always_ff @(posedge clk) begin
        if (!rst_n) sum_ctrl <= '0;
        else sum_ctrl <= ctrl;
    end

    // add neighbours, widening by one bit (sign or zero extension)
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_N / 2; i++)
            sum[i] <= {SIGNED_EN & data[2*i][IN_W-1], data[2*i]}
                    + {SIGNED_EN & data[2*i+1][IN_W-1], data[2*i+1]};
    end

endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined adder tree feeding a frame accumulator; ADDER_TREE_ACC_SIGNED_EN selects signed mode
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int DATA_N = 9,
    parameter int ACC_N  = 4,
    localparam int ACC_W = acc_w(DATA_W, DATA_N, ACC_N)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    input  logic [0:DATA_N-1][DATA_W-1:0]   i_data,
    input  logic                            i_last,
    output logic                            o_valid,
    output logic [ACC_W-1:0]                o_data,
    output logic                            o_forced
);

    localparam int TREE_ST = tree_st(DATA_N);
    localparam int LEAVES  = 1 << TREE_ST;
    localparam int CNT_W   = ($clog2(ACC_N) > 1) ? $clog2(ACC_N) : 1;
    localparam int SUM_W   = DATA_W + TREE_ST;

    logic [CNT_W-1:0]               cnt;
    logic                           at_lim;
    logic                           force_close;
    logic [0:LEAVES-1][DATA_W-1:0]  leaves;
    ctrl_t                          c [TREE_ST+1];
    logic [SUM_W-1:0]               td;
    logic [ACC_W-1:0]               beat;
    logic [ACC_W-1:0]               acc;
    logic                           first;
    logic                           close;
    logic                           done;
    logic                           done_forced;

    assign at_lim      = cnt == CNT_W'(ACC_N - 1);
    assign force_close = i_valid & ~i_last & at_lim;
    assign c[0]        = '{valid: i_valid, last: i_last, forced: force_close};

    // count beats of the open frame; wrap on any close
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (i_valid) cnt <= (i_last | at_lim) ? '0 : cnt + 1'b1;
    end

    // pad the operand vector with zeros up to a power of two
    always_comb begin
        leaves = '0;
        for (int i = 0; i < DATA_N; i++) leaves[i] = i_data[i];
    end

    for (genvar l = 0; l < TREE_ST; l++) begin : g
        localparam int N = LEAVES >> l;
        localparam int W = DATA_W + l;
        logic [0:N/2-1][W:0] s;
        if (l == 0) begin : f
            adder_tree_level #(.IN_N(N), .IN_W(W)) u_lvl (
                .clk     (clk),
                .rst_n   (rst_n),
                .ctrl    (c[0]),
                .data    (leaves),
                .sum_ctrl(c[1]),
                .sum     (s)
            );
        end else begin : n
            adder_tree_level #(.IN_N(N), .IN_W(W)) u_lvl (
                .clk     (clk),
                .rst_n   (rst_n),
                .ctrl    (c[l]),
                .data    (g[l-1].s),
                .sum_ctrl(c[l+1]),
                .sum     (s)
            );
        end
    end

    assign td    = g[TREE_ST-1].s[0];
    assign beat  = SIGNED_EN ? ACC_W'($signed(td)) : ACC_W'(td);
    assign close = c[TREE_ST].valid & (c[TREE_ST].last | c[TREE_ST].forced);

    // accumulate tree output; the first beat of a frame loads instead of adding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            first       <= 1'b1;
            done        <= 1'b0;
            done_forced <= 1'b0;
        end else begin
            if (c[TREE_ST].valid) begin
                acc   <= first ? beat : acc + beat;
                first <= close;
            end
            done        <= close;
            done_forced <= c[TREE_ST].forced;
        end
    end

    // publish the closed frame for one cycle and hold it afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_forced <= 1'b0;
        end else begin
            o_valid <= done;
            if (done) begin
                o_data   <= acc;
                o_forced <= done_forced;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed vectors with a queue-based scoreboard and output monitor
module tb_adder_tree_acc;
    import adder_tree_pkg::*;

    localparam int DATA_W  = 3;
    localparam int DATA_N  = 9;
    localparam int ACC_N   = 4;
    localparam int TREE_ST = tree_st(DATA_N);
    localparam int ACC_W   = acc_w(DATA_W, DATA_N, ACC_N);
    localparam int LAT     = TREE_ST + 1;

    logic                           clk;
    logic                           rst_n;
    logic                           i_valid;
    logic [0:DATA_N-1][DATA_W-1:0]  i_data;
    logic                           i_last;
    logic                           o_valid;
    logic [ACC_W-1:0]               o_data;
    logic                           o_forced;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic             forced;
        int               due;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    adder_tree_acc #(.DATA_W(DATA_W), .DATA_N(DATA_N), .ACC_N(ACC_N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_forced(o_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int v, input logic valid, input logic last);
        @(negedge clk);
        i_valid = valid;
        i_last  = last;
        for (int i = 0; i < DATA_N; i++) i_data[i] = DATA_W'(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b1);
    endtask

    task automatic exp_out(input int d, input logic f);
        q.push_back('{data: ACC_W'(d), forced: f, due: cyc + LAT + 1});
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected o_valid: o_data=%0d o_forced=%0d, expected none (cycle %0d)", o_data, o_forced, cyc);
            end else begin
                e = q.pop_front();
                chk("o_data", o_data, e.data);
                chk("o_forced", o_forced, e.forced);
                chk("latency", cyc, e.due);
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            e = q.pop_front();
            chk("o_valid timeout", 0, 1);
        end
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset o_valid", o_valid, 0);
        chk("reset o_data", o_data, 0);
        chk("reset o_forced", o_forced, 0);
        rst_n = 1'b1;
        idle(2);
`ifdef ADDER_TREE_ACC_SIGNED_EN
        drive(7, 1'b1, 1'b1); exp_out(-9, 1'b0);
        idle(8);
        drive(3, 1'b1, 1'b1); exp_out(27, 1'b0);
        idle(8);
        repeat (4) drive(4, 1'b1, 1'b0);
        exp_out(-144, 1'b1);
        idle(8);
        drive(6, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b1); exp_out(-9, 1'b0);
        idle(8);
`else
        drive(7, 1'b1, 1'b1); exp_out(63, 1'b0);
        idle(8);
        drive(7, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b1); exp_out(189, 1'b0);
        idle(8);
        repeat (4) drive(7, 1'b1, 1'b0);
        exp_out(252, 1'b1);
        drive(1, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b1); exp_out(27, 1'b0);
        idle(8);
        repeat (3) drive(1, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b1); exp_out(36, 1'b0);
        idle(8);
        drive(5, 1'b1, 1'b0);
        idle(3);
        drive(5, 1'b1, 1'b1); exp_out(90, 1'b0);
        idle(8);
        for (int k = 0; k < 8; k++) begin
            drive(k, 1'b1, 1'b1);
            exp_out(9 * k, 1'b0);
        end
        idle(10);
        chk("hold o_valid", o_valid, 0);
        chk("hold o_data", o_data, 63);
        chk("hold o_forced", o_forced, 0);
`endif
        drive(7, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mid reset o_data", o_data, 0);
        rst_n = 1'b1;
        drive(1, 1'b1, 1'b1); exp_out(9, 1'b0);
        idle(8);
        drive(2, 1'b1, 1'b0);
        drive(2, 1'b1, 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) drive(1, 1'b1, 1'b0);
        exp_out(36, 1'b1);
        idle(12);
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
